bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the core's single-ported memory bus between the instruction-fetch port and the load/store port of the memory stage. Transactions use a request/ready handshake with arbitrary wait states on the bus side. The data port has fixed priority, with a streak limit that prevents fetch starvation. A fetch-abort input discards in-flight fetch results after a trap, mret or branch redirect.

## Interface

**Parameters**
- `MAX_DATA_STREAK`, default 4: maximum consecutive data grants while a fetch request is pending; range 1..15.

**Ports**
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  fetch read request; held until `fetch_ready` or `fetch_abort`.
- `fetch_address`  in  32  fetch word address; stable while `fetch_req` is high.
- `fetch_abort`  in  1  redirect pulse; kills the pending or in-flight fetch.
- `fetch_data`  out  32  fetch read data; valid with `fetch_ready`.
- `fetch_ready`  out  1  one-cycle completion pulse for fetch.
- `mem_req`  in  1  load/store request; held until `mem_ready`.
- `mem_write`  in  1  1 = store, 0 = load.
- `mem_address`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_strobe`  in  4  byte-enable mask for stores.
- `mem_rdata`  out  32  load data; valid with `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse for load/store.
- `bus_valid`  out  1  transaction active on the bus.
- `bus_write`  out  1  store indicator.
- `bus_address`  out  32  bus address.
- `bus_wdata`  out  32  bus store data.
- `bus_strobe`  out  4  bus byte enables; 4'b0000 for reads.
- `bus_ready`  in  1  memory completes the transaction this cycle.
- `bus_rdata`  in  32  read data; valid with `bus_ready`.

## Operation

- **FSM states:** IDLE, FETCH, DATA, RESP.
- **IDLE:**
  - If `mem_req` is high and (`fetch_req` is low or streak < MAX_DATA_STREAK), latch the data request, increment streak (saturating), and go to DATA.
  - Else if `fetch_req` is high and `fetch_abort` is low, latch the fetch request, clear streak, and go to FETCH.
  - Otherwise stay in IDLE.
- **Streak counter:** counts consecutive data grants. It clears on any fetch grant, and also clears when a data grant occurs with `fetch_req` low.
- **FETCH/DATA:**
  - `bus_valid`=1; bus outputs come from the latched request registers and stay constant for the whole transaction.
  - Fetch transactions drive `bus_write`=0 and `bus_strobe`=0.
  - On `bus_ready`, capture `bus_rdata` into the owner's data register and go to RESP.
- **RESP:**
  - Pulse the owner's ready signal for one cycle, then go to IDLE.
  - The owner must drop or replace its request in the RESP cycle. The arbiter never samples requests in RESP.
- **Abort:**
  - A `fetch_abort` in FETCH, or on the cycle `bus_ready` arrives in FETCH, sets a kill flag. The bus transaction still completes, because it cannot be cancelled.
  - RESP for a killed fetch suppresses `fetch_ready`. `fetch_data` still updates.
  - The kill flag clears on entry to IDLE.
  - An abort in IDLE only blocks a fetch grant that cycle.
- **Simultaneous events:**
  - `fetch_abort` with `mem_req` in IDLE: data is granted normally.
  - An abort during DATA has no effect on the data transaction.
- **Reset:**
  - State returns to IDLE; streak and kill flag clear.
  - All outputs go to 0: `bus_valid`, `bus_write`, `bus_strobe`, `bus_address`, `bus_wdata`, `fetch_ready`, `mem_ready`, `fetch_data`, `mem_rdata`.
  - Reset in the middle of a transaction drops it. Memory is reset by the same signal.

## Timing

- All outputs are registered; there is no combinational path from request inputs to bus outputs.
- **Zero-wait-state memory:**
  - Request sampled in IDLE at cycle N.
  - `bus_valid` high at N+1; `bus_ready` seen at N+1.
  - Ready pulse at N+2; IDLE at N+3.
  - Minimum 3 cycles per transaction.
- **Wait states:** each cycle `bus_ready` stays low extends the transaction by one cycle. There is no timeout.
- **Back-to-back requests:** a new request is sampled at the earliest in the IDLE cycle following RESP.
- **Data outputs:** `fetch_data` and `mem_rdata` hold their value until the next completion of the same port.

## Test plan

1. **Single fetch:**
   - Stimulus: `fetch_req`=1, address 0x100; memory returns 0x00000013 with zero waits.
   - Required: `bus_valid` for exactly 1 cycle with address 0x100, `bus_strobe`=0; `fetch_ready` pulses 2 cycles after the request, with `fetch_data`=0x00000013.
2. **Store with waits:**
   - Stimulus: `mem_req`=1, `mem_write`=1, address 0x2004, wdata 0xDEADBEEF, strobe 4'b0011; `bus_ready` arrives after 3 wait cycles.
   - Required: bus signals stable for 4 cycles; one `mem_ready` pulse.
3. **Priority and starvation:**
   - Stimulus: `fetch_req` and `mem_req` held high continuously, with `MAX_DATA_STREAK`=4.
   - Required: grant order is D, D, D, D, F, D, D, D, D, F.
4. **Abort in flight:**
   - Stimulus: `fetch_abort` pulsed during FETCH with 2 wait states.
   - Required: the bus transaction completes; no `fetch_ready` pulse; the next fetch grant is served normally.
5. **Abort on the completion edge:**
   - Stimulus: `fetch_abort` coincides with `bus_ready`.
   - Required: `fetch_ready` is suppressed.
6. **Reset mid-transaction:**
   - Stimulus: `reset` asserted during DATA.
   - Required: next cycle all outputs are 0 and the state is IDLE; after reset is released, a new fetch completes normally.

Source files
------------

// File: rtl/bus_arbiter.sv
// Shares one memory bus between instruction fetch and load/store.
// Data port has priority, bounded by a streak limit; fetches can be aborted.
module bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  input  logic        fetch_abort,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_strobe,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strobe,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_streak;
  logic [3:0]  w_streak_nxt;
  logic [3:0]  w_streak_inc;
  logic        r_kill;
  logic        w_kill_nxt;

  logic        w_grant_d;
  logic        w_grant_f;

  logic        r_bus_valid;
  logic        r_bus_write;
  logic [31:0] r_bus_address;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_strobe;
  logic        r_fetch_ready;
  logic        r_mem_ready;
  logic [31:0] r_fetch_data;
  logic [31:0] r_mem_rdata;

  logic        w_bus_valid_nxt;
  logic        w_bus_write_nxt;
  logic [31:0] w_bus_address_nxt;
  logic [31:0] w_bus_wdata_nxt;
  logic [3:0]  w_bus_strobe_nxt;
  logic        w_fetch_ready_nxt;
  logic        w_mem_ready_nxt;
  logic [31:0] w_fetch_data_nxt;
  logic [31:0] w_mem_rdata_nxt;

  // Data wins unless a fetch is waiting and the data streak is used up.
  assign w_grant_d = mem_req &&
                     (!fetch_req || (r_streak < STREAK_MAX));
  assign w_grant_f = !w_grant_d && fetch_req && !fetch_abort;

  assign w_streak_inc = (r_streak == 4'hF) ?
                        r_streak : r_streak + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_grant_d: w_state_nxt = DATA;
          w_grant_f: w_state_nxt = FETCH;
          default:   w_state_nxt = IDLE;
        endcase
      end
      FETCH: if (bus_ready) w_state_nxt = RESP;
      DATA:  if (bus_ready) w_state_nxt = RESP;
      RESP:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_streak_nxt      = r_streak;
    w_kill_nxt        = r_kill;
    w_bus_valid_nxt   = r_bus_valid;
    w_bus_write_nxt   = r_bus_write;
    w_bus_address_nxt = r_bus_address;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_bus_strobe_nxt  = r_bus_strobe;
    w_fetch_ready_nxt = 1'b0;
    w_mem_ready_nxt   = 1'b0;
    w_fetch_data_nxt  = r_fetch_data;
    w_mem_rdata_nxt   = r_mem_rdata;
    unique case (r_state)
      IDLE: begin
        w_kill_nxt = 1'b0;
        unique case (1'b1)
          w_grant_d: begin
            w_streak_nxt      = fetch_req ? w_streak_inc : 4'd0;
            w_bus_valid_nxt   = 1'b1;
            w_bus_write_nxt   = mem_write;
            w_bus_address_nxt = mem_address;
            w_bus_wdata_nxt   = mem_wdata;
            w_bus_strobe_nxt  = mem_write ? mem_strobe : 4'b0000;
          end
          w_grant_f: begin
            w_streak_nxt      = 4'd0;
            w_bus_valid_nxt   = 1'b1;
            w_bus_write_nxt   = 1'b0;
            w_bus_address_nxt = fetch_address;
            w_bus_wdata_nxt   = 32'd0;
            w_bus_strobe_nxt  = 4'b0000;
          end
          default: ;
        endcase
      end
      FETCH: begin
        if (fetch_abort) w_kill_nxt = 1'b1;
        if (bus_ready) begin
          w_bus_valid_nxt   = 1'b0;
          w_fetch_data_nxt  = bus_rdata;
          w_fetch_ready_nxt = !(r_kill || fetch_abort);
        end
      end
      DATA: begin
        if (bus_ready) begin
          w_bus_valid_nxt = 1'b0;
          w_mem_rdata_nxt = bus_rdata;
          w_mem_ready_nxt = 1'b1;
        end
      end
      RESP: w_kill_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak      <= 4'd0;
      r_kill        <= 1'b0;
      r_bus_valid   <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_address <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_bus_strobe  <= 4'b0000;
      r_fetch_ready <= 1'b0;
      r_mem_ready   <= 1'b0;
      r_fetch_data  <= 32'd0;
      r_mem_rdata   <= 32'd0;
    end else begin
      r_streak      <= w_streak_nxt;
      r_kill        <= w_kill_nxt;
      r_bus_valid   <= w_bus_valid_nxt;
      r_bus_write   <= w_bus_write_nxt;
      r_bus_address <= w_bus_address_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_bus_strobe  <= w_bus_strobe_nxt;
      r_fetch_ready <= w_fetch_ready_nxt;
      r_mem_ready   <= w_mem_ready_nxt;
      r_fetch_data  <= w_fetch_data_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
    end
  end

  assign bus_valid   = r_bus_valid;
  assign bus_write   = r_bus_write;
  assign bus_address = r_bus_address;
  assign bus_wdata   = r_bus_wdata;
  assign bus_strobe  = r_bus_strobe;
  assign fetch_ready = r_fetch_ready;
  assign mem_ready   = r_mem_ready;
  assign fetch_data  = r_fetch_data;
  assign mem_rdata   = r_mem_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus
// randomized traffic against a memory model and grant-order monitor.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_address = 32'd0;
  logic        fetch_abort = 1'b0;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_strobe = 4'd0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strobe;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_address(fetch_address),
    .fetch_abort(fetch_abort), .fetch_data(fetch_data),
    .fetch_ready(fetch_ready),
    .mem_req(mem_req), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_strobe(mem_strobe), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_strobe(bus_strobe), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] sh  [logic [31:0]];
  int fixed_waits = 0;
  bit rand_waits = 1'b0;
  int cur_wait = 0;
  int wcnt = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] shrd(input logic [31:0] a);
    return sh.exists(a) ? sh[a] : dflt(a);
  endfunction

  // Memory: counts wait states, then completes on the bus.
  logic [31:0] wtmp;
  always @(negedge clk) begin
    if (reset) begin
      bus_ready = 1'b0;
      wcnt = 0;
    end else if (bus_ready) begin
      bus_ready = 1'b0;
      wcnt = 0;
    end else if (bus_valid) begin
      if (wcnt >= cur_wait) begin
        if (bus_write) begin
          wtmp = rd(bus_address);
          for (int b = 0; b < 4; b++)
            if (bus_strobe[b]) wtmp[b*8 +: 8] = bus_wdata[b*8 +: 8];
          mem[bus_address] = wtmp;
          bus_rdata = $urandom;
        end else begin
          bus_rdata = rd(bus_address);
        end
        bus_ready = 1'b1;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      cur_wait = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
    end
  end

  // Grant monitor: owner expected from requests seen the cycle before.
  logic        pv, pf, pm, pa, pmw;
  logic [31:0] pfa, pma, pmwd;
  logic [3:0]  pms;
  int          mstreak = 0;
  bit          exp_d;
  bit          gq [$];
  int          fr_cnt = 0;
  int          mr_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      mstreak = 0;
      pv = 0; pf = 0; pm = 0; pa = 0;
    end else begin
      if (fetch_ready) fr_cnt++;
      if (mem_ready) mr_cnt++;
      if (bus_valid && !pv) begin
        exp_d = pm && (!pf || mstreak < MAXS);
        gq.push_back(pm && (bus_address === pma));
        checks++;
        if (!exp_d && !(pf && !pa)) begin
          errors++;
          $display("FAIL grant_spurious addr=%h", bus_address);
        end else if (exp_d) begin
          if ({bus_write, bus_address, bus_wdata, bus_strobe} !==
              {pmw, pma, pmwd, pmw ? pms : 4'b0000}) begin
            errors++;
            $display("FAIL grant_data got %h %h %h %h required %h %h %h %h",
                     bus_write, bus_address, bus_wdata, bus_strobe,
                     pmw, pma, pmwd, pmw ? pms : 4'b0000);
          end
        end else begin
          if ({bus_write, bus_address, bus_strobe} !==
              {1'b0, pfa, 4'b0000}) begin
            errors++;
            $display("FAIL grant_fetch got %h %h %h required 0 %h 0",
                     bus_write, bus_address, bus_strobe, pfa);
          end
        end
        if (exp_d) mstreak = pf ? ((mstreak < 15) ? mstreak + 1 : 15) : 0;
        else       mstreak = 0;
      end
      pv = bus_valid; pf = fetch_req; pm = mem_req; pa = fetch_abort;
      pfa = fetch_address; pma = mem_address; pmw = mem_write;
      pmwd = mem_wdata; pms = mem_strobe;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({fetch_data, fetch_ready, mem_rdata, mem_ready, bus_valid,
         bus_write, bus_address, bus_wdata, bus_strobe} !== 136'd0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero valid=%b addr=%h",
               bus_valid, bus_address);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    mem[32'h100] = 32'h0000_0013;
    fixed_waits = 0;
    fetch_address = 32'h100; fetch_req = 1'b1;
    tick();
    checks++;
    if ({bus_valid, bus_write, bus_address, bus_strobe, fetch_ready} !==
        {1'b1, 1'b0, 32'h100, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL single_fetch_bus got v=%b a=%h s=%h r=%b",
               bus_valid, bus_address, bus_strobe, fetch_ready);
    end
    tick();
    checks++;
    if ({bus_valid, fetch_ready, fetch_data} !== {1'b0, 1'b1, 32'h13}) begin
      errors++;
      $display("FAIL single_fetch_ready got v=%b r=%b d=%h required 0 1 13",
               bus_valid, fetch_ready, fetch_data);
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (fetch_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_fetch_pulse got %b required 0", fetch_ready);
    end
    tick();
  endtask

  task automatic test_store_waits();
    logic [31:0] e;
    bit got;
    fixed_waits = 3;
    mem_write = 1'b1; mem_address = 32'h2004;
    mem_wdata = 32'hDEADBEEF; mem_strobe = 4'b0011; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus_valid, bus_write, bus_address, bus_wdata, bus_strobe,
           mem_ready} !==
          {1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b0}) begin
        errors++;
        $display("FAIL store_hold cycle %0d got v=%b a=%h d=%h s=%h r=%b",
                 i, bus_valid, bus_address, bus_wdata, bus_strobe, mem_ready);
      end
    end
    tick();
    checks++;
    if ({bus_valid, mem_ready} !== 2'b01) begin
      errors++;
      $display("FAIL store_ready got v=%b r=%b required 0 1",
               bus_valid, mem_ready);
    end
    mem_req = 1'b0; mem_write = 1'b0;
    tick();
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_pulse got %b required 0", mem_ready);
    end
    fixed_waits = 0;
    e = dflt(32'h2004);
    e[15:0] = 16'hBEEF;
    mem_req = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (mem_ready) begin
        got = 1;
        mem_req = 1'b0;
        checks++;
        if (mem_rdata !== e) begin
          errors++;
          $display("FAIL store_readback got %h required %h", mem_rdata, e);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL store_readback timeout");
      mem_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_priority();
    logic [9:0] got_v, exp_v;
    bit done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gq.delete();
    fixed_waits = 0;
    fetch_address = 32'h600; fetch_req = 1'b1;
    mem_address = 32'h8000_0040; mem_write = 1'b0; mem_req = 1'b1;
    for (int c = 0; c < 150 && gq.size() < 10; c++) tick();
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (fetch_ready || mem_ready) done = 1;
      else tick();
    end
    fetch_req = 1'b0; mem_req = 1'b0;
    got_v = '0;
    for (int i = 0; i < 10; i++) begin
      exp_v[9-i] = ((i % (MAXS + 1)) != MAXS);
      if (i < gq.size()) got_v[9-i] = gq[i];
    end
    checks++;
    if (gq.size() < 10 || got_v !== exp_v) begin
      errors++;
      $display("FAIL priority_order got %b (%0d grants) required %b",
               got_v, gq.size(), exp_v);
    end
    tick(); tick();
  endtask

  task automatic test_abort_inflight();
    int vcnt, rcnt;
    bit got;
    fixed_waits = 2;
    fetch_address = 32'h300; fetch_req = 1'b1;
    tick();
    vcnt = 0; rcnt = 0;
    fetch_abort = 1'b1; fetch_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (bus_valid) vcnt++;
      if (fetch_ready) rcnt++;
      tick();
      fetch_abort = 1'b0;
    end
    checks++;
    if (vcnt !== 3 || rcnt !== 0) begin
      errors++;
      $display("FAIL abort_inflight got valid=%0d ready=%0d required 3 0",
               vcnt, rcnt);
    end
    fixed_waits = 0;
    fetch_address = 32'h304; fetch_req = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (fetch_ready) begin
        got = 1;
        fetch_req = 1'b0;
        checks++;
        if (fetch_data !== dflt(32'h304)) begin
          errors++;
          $display("FAIL abort_next_fetch got %h required %h",
                   fetch_data, dflt(32'h304));
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL abort_next_fetch timeout");
      fetch_req = 1'b0;
    end
    tick();
  endtask

  task automatic test_abort_edge();
    int rcnt;
    fixed_waits = 0;
    fetch_address = 32'h400; fetch_req = 1'b1;
    tick();
    fetch_abort = 1'b1; fetch_req = 1'b0;
    tick();
    fetch_abort = 1'b0;
    checks++;
    if ({fetch_ready, fetch_data} !== {1'b0, dflt(32'h400)}) begin
      errors++;
      $display("FAIL abort_edge got r=%b d=%h required 0 %h",
               fetch_ready, fetch_data, dflt(32'h400));
    end
    rcnt = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (fetch_ready) rcnt++;
    end
    checks++;
    if (rcnt !== 0) begin
      errors++;
      $display("FAIL abort_edge_late got %0d pulses required 0", rcnt);
    end
  endtask

  task automatic test_abort_idle();
    bit got;
    fixed_waits = 0;
    fetch_address = 32'h700; fetch_req = 1'b1; fetch_abort = 1'b1;
    tick();
    fetch_abort = 1'b0;
    checks++;
    if (bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_block got valid=%b required 0", bus_valid);
    end
    tick();
    checks++;
    if ({bus_valid, bus_address} !== {1'b1, 32'h700}) begin
      errors++;
      $display("FAIL abort_idle_regrant got v=%b a=%h required 1 700",
               bus_valid, bus_address);
    end
    tick();
    fetch_req = 1'b0;
    tick();
    mem_address = 32'h8000_0020; mem_write = 1'b0; mem_req = 1'b1;
    fetch_address = 32'h704; fetch_req = 1'b1; fetch_abort = 1'b1;
    tick();
    fetch_abort = 1'b0; fetch_req = 1'b0;
    checks++;
    if ({bus_valid, bus_address} !== {1'b1, 32'h8000_0020}) begin
      errors++;
      $display("FAIL abort_with_data got v=%b a=%h required 1 80000020",
               bus_valid, bus_address);
    end
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (mem_ready) got = 1;
      else tick();
    end
    mem_req = 1'b0;
    checks++;
    if (!got || mem_rdata !== rd(32'h8000_0020)) begin
      errors++;
      $display("FAIL abort_with_data_done got %h required %h",
               mem_rdata, rd(32'h8000_0020));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    fixed_waits = 3;
    mem_address = 32'h8000_0010; mem_write = 1'b0; mem_req = 1'b1;
    tick(); tick();
    reset = 1'b1; mem_req = 1'b0;
    tick();
    checks++;
    if ({fetch_data, fetch_ready, mem_rdata, mem_ready, bus_valid,
         bus_write, bus_address, bus_wdata, bus_strobe} !== 136'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got valid=%b addr=%h rdata=%h",
               bus_valid, bus_address, mem_rdata);
    end
    reset = 1'b0;
    fixed_waits = 0;
    tick();
    fetch_address = 32'h500; fetch_req = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (fetch_ready) lat = c;
    end
    fetch_req = 1'b0;
    checks++;
    if (lat !== 2 || fetch_data !== dflt(32'h500)) begin
      errors++;
      $display("FAIL reset_mid_fetch got lat=%0d d=%h required 2 %h",
               lat, fetch_data, dflt(32'h500));
    end
    tick();
  endtask

  int f_done = 0;
  int m_done = 0;

  task automatic fetch_agent(input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      bit done;
      a = 32'h1000 + 32'(k * 4);
      fetch_address = a; fetch_req = 1'b1;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        if (fetch_ready) begin
          checks++;
          if (fetch_data !== dflt(a)) begin
            errors++;
            $display("FAIL rand_fetch a=%h got %h required %h",
                     a, fetch_data, dflt(a));
          end
          f_done++;
          fetch_req = 1'b0;
          done = 1;
        end else if ($urandom_range(0, 19) == 0) begin
          fetch_abort = 1'b1; fetch_req = 1'b0;
          tick();
          fetch_abort = 1'b0;
          done = 1;
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL rand_fetch timeout a=%h", a);
        fetch_req = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic data_agent(input int n);
    logic [31:0] a, wd, e;
    logic [3:0]  s;
    logic        w;
    for (int k = 0; k < n; k++) begin
      bit done;
      a  = 32'h8000_0000 | 32'($urandom_range(0, 7) * 4);
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      s  = 4'($urandom_range(1, 15));
      mem_address = a; mem_write = w; mem_wdata = wd; mem_strobe = s;
      mem_req = 1'b1;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        if (mem_ready) begin
          e = shrd(a);
          if (w) begin
            for (int b = 0; b < 4; b++)
              if (s[b]) e[b*8 +: 8] = wd[b*8 +: 8];
            sh[a] = e;
          end else begin
            checks++;
            if (mem_rdata !== e) begin
              errors++;
              $display("FAIL rand_load a=%h got %h required %h",
                       a, mem_rdata, e);
            end
          end
          m_done++;
          mem_req = 1'b0;
          done = 1;
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL rand_data timeout a=%h", a);
        mem_req = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_random();
    int fr0, mr0;
    rand_waits = 1'b1;
    tick();
    fr0 = fr_cnt; mr0 = mr_cnt;
    f_done = 0; m_done = 0;
    fork
      fetch_agent(40);
      data_agent(40);
    join
    tick(); tick(); tick();
    checks++;
    if (fr_cnt - fr0 !== f_done || mr_cnt - mr0 !== m_done ||
        m_done !== 40) begin
      errors++;
      $display("FAIL rand_counts got f=%0d m=%0d required f=%0d m=%0d/40",
               fr_cnt - fr0, mr_cnt - mr0, f_done, m_done);
    end
    rand_waits = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_waits();
    test_priority();
    test_abort_inflight();
    test_abort_edge();
    test_abort_idle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
